uart_boot_loader: RTL and testbench

UART_BOOT_LOADER -- requirements
Module: uart_boot_loader

---
 rtl/uart_pkg.sv | 9 +
 rtl/uart_timeout.sv | 15 +
 rtl/uart_boot_loader.sv | 113 +++++++++++
 tb/tb_uart_boot_loader.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state, error codes and frame header default for the boot loader
package uart_pkg;
  typedef enum logic [2:0] {IDLE, ADDR, COUNT, DATA, WRITE, CSUM} state_t;
  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_CSUM = 2'd1;
  localparam logic [1:0] ERR_ALIGN = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;
  localparam logic [7:0] HDR_DEFAULT = 8'h55;
endpackage

// File: rtl/uart_timeout.sv
// uart_timeout: inter-byte idle counter; expired fires on the LIMIT-th consecutive enabled cycle
module uart_timeout #(
  parameter int unsigned LIMIT = 5000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  logic [31:0] cnt;
  assign expired = enable && !clear && cnt == LIMIT - 1;
  always_ff @(posedge clk)
    cnt <= (rst || clear) ? '0 : enable ? cnt + 32'd1 : cnt;
endmodule

// File: rtl/uart_boot_loader.sv
// uart_boot_loader: parses header/address/count/words/checksum frames from a byte FIFO
// and writes the words to program memory.
module uart_boot_loader
  import uart_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 5000000,
  parameter logic [7:0] HDR_BYTE = HDR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_pop,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  output logic        busy,
  output logic        frame_ok,
  output logic        frame_err,
  output logic [1:0]  err_code
);
  state_t      state;
  logic [1:0]  idx;
  logic [31:0] addr;
  logic [23:0] word;
  logic [8:0]  count;
  logic [7:0]  csum;
  logic        expired;
  logic [31:0] addr_nxt, word_nxt;
  assign rx_pop = rx_valid && !rst && state != WRITE;
  assign busy = !rst && state != IDLE;
  assign addr_nxt = {rx_data, addr[31:8]};
  assign word_nxt = {rx_data, word};
  uart_timeout #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
    .clk(clk),
    .rst(rst),
    .clear(rx_pop || state == IDLE || state == WRITE),
    .enable(!(rx_pop || state == IDLE || state == WRITE)),
    .expired(expired)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      addr <= '0;
      word <= '0;
      count <= '0;
      csum <= '0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      err_code <= ERR_NONE;
      frame_ok <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_ok <= 1'b0;
      frame_err <= 1'b0;
      if (rx_pop) begin
        case (state)
          IDLE: if (rx_data == HDR_BYTE) begin
            state <= ADDR;
            csum <= '0;
            idx <= '0;
            err_code <= ERR_NONE;
          end
          ADDR: begin
            addr <= addr_nxt;
            csum <= csum + rx_data;
            idx <= idx + 2'd1;
            if (idx == 2'd3) begin
              state <= addr_nxt[1:0] != 2'd0 ? IDLE : COUNT;
              frame_err <= addr_nxt[1:0] != 2'd0;
              err_code <= addr_nxt[1:0] != 2'd0 ? ERR_ALIGN : err_code;
            end
          end
          COUNT: begin
            count <= {rx_data == 8'd0, rx_data};
            csum <= csum + rx_data;
            state <= DATA;
          end
          DATA: begin
            word <= word_nxt[31:8];
            csum <= csum + rx_data;
            idx <= idx + 2'd1;
            if (idx == 2'd3) begin
              mem_we <= 1'b1;
              mem_addr <= addr;
              mem_wdata <= word_nxt;
              state <= WRITE;
            end
          end
          CSUM: begin
            frame_ok <= rx_data == csum;
            frame_err <= rx_data != csum;
            err_code <= rx_data == csum ? err_code : ERR_CSUM;
            state <= IDLE;
          end
          default: ;
        endcase
      end else if (expired) begin
        frame_err <= 1'b1;
        err_code <= ERR_TIMEOUT;
        state <= IDLE;
      end else if (state == WRITE && mem_ready) begin
        mem_we <= 1'b0;
        addr <= addr + 32'd4;
        count <= count - 9'd1;
        state <= count == 9'd1 ? CSUM : DATA;
      end
    end
  end
endmodule

// File: tb/tb_uart_boot_loader.sv
// tb_uart_boot_loader: table-driven frames plus corner sequences, with a write scoreboard.
module tb_uart_boot_loader;
  logic clk = 1'b0, rst = 1'b1, rx_valid = 1'b0, mem_ready = 1'b1;
  logic [7:0] rx_data = '0;
  logic rx_pop, mem_we, busy, frame_ok, frame_err;
  logic [31:0] mem_addr, mem_wdata;
  logic [1:0] err_code;

  uart_boot_loader #(.TIMEOUT_CYCLES(100), .HDR_BYTE(8'h55)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_pop(rx_pop),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .busy(busy), .frame_ok(frame_ok), .frame_err(frame_err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  typedef struct {logic [31:0] addr; logic [31:0] data;} wr_t;
  typedef struct {logic [31:0] addr; logic [31:0] seed; logic [31:0] step; logic [7:0] cnt; logic [7:0] dlt; bit ok; logic [1:0] code;} vec_t;
  wr_t q[$];
  wr_t mon_e;
  vec_t v[6];
  int errors = 0, checks = 0, ok_cnt = 0, err_cnt = 0, wr_cnt = 0;
  int o0, e0, w0;
  bit rnd_ready = 0, held = 0;
  logic [31:0] h_addr, h_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    #2;
    mem_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always @(negedge clk) begin
    if (rst) held = 0;
    else begin
      if (frame_ok || frame_err) chk("pulse_exclusive", {31'd0, frame_ok && frame_err}, 32'd0);
      ok_cnt += int'(frame_ok);
      err_cnt += int'(frame_err);
      if (mem_we) begin
        chk("pop_in_write", {31'd0, rx_pop}, 32'd0);
        if (held) begin
          chk("hold_addr", mem_addr, h_addr);
          chk("hold_data", mem_wdata, h_data);
        end
        if (mem_ready) begin
          held = 0;
          wr_cnt++;
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: got addr %h data %h expected no write", mem_addr, mem_wdata);
          end else begin
            mon_e = q.pop_front();
            chk("wr_addr", mem_addr, mon_e.addr);
            chk("wr_data", mem_wdata, mon_e.data);
          end
        end else begin
          held = 1;
          h_addr = mem_addr;
          h_data = mem_wdata;
        end
      end
    end
  end

  task automatic send(input logic [7:0] b);
    int n = 0;
    bit hit = 0;
    rx_data = b;
    rx_valid = 1'b1;
    while (!hit) begin
      #1 hit = rx_pop;
      @(negedge clk);
      n++;
      if (!hit && n > 2000) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: byte %h not popped after %0d cycles expected pop", b, n);
        hit = 1;
      end
    end
    rx_valid = 1'b0;
  endtask

  task automatic frame(input logic [31:0] a, input logic [7:0] cnt, input logic [31:0] seed,
                       input logic [31:0] step, input logic [7:0] dlt, input bit rnd);
    logic [7:0] s = '0;
    logic [31:0] w, wa;
    int nw;
    send(8'h55);
    for (int i = 0; i < 4; i++) begin
      send(a[8*i+:8]);
      s += a[8*i+:8];
    end
    if (a[1:0] != 2'd0) return;
    send(cnt);
    s += cnt;
    nw = cnt == 8'd0 ? 256 : int'(cnt);
    wa = a;
    for (int i = 0; i < nw; i++) begin
      w = rnd ? $urandom : seed + step * i;
      for (int j = 0; j < 4; j++) begin
        if (j == 3) q.push_back('{wa, w});
        send(w[8*j+:8]);
        s += w[8*j+:8];
      end
      wa += 32'd4;
    end
    send(s + dlt);
  endtask

  initial begin
    v[0] = '{32'h0000_1000, 32'h4433_2211, 32'h4444_4444, 8'd2, 8'd0, 1'b1, 2'd0};
    v[1] = '{32'h0000_1000, 32'h4433_2211, 32'h4444_4444, 8'd2, 8'd1, 1'b0, 2'd1};
    v[2] = '{32'h0000_1002, 32'h4433_2211, 32'h4444_4444, 8'd2, 8'd0, 1'b0, 2'd2};
    v[3] = '{32'hFFFF_FFFC, 32'h5555_5555, 32'h0101_0101, 8'd2, 8'd0, 1'b1, 2'd0};
    v[4] = '{32'h0000_0000, 32'hDEAD_BEEF, 32'h0000_0000, 8'd1, 8'hFF, 1'b0, 2'd1};
    v[5] = '{32'h0000_0103, 32'h0000_0000, 32'h0000_0000, 8'd1, 8'd0, 1'b0, 2'd2};

    rx_valid = 1'b1;
    rx_data = 8'h55;
    repeat (3) @(negedge clk);
    chk("rst_pop", {31'd0, rx_pop}, 32'd0);
    chk("rst_we", {31'd0, mem_we}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ok", {31'd0, frame_ok}, 32'd0);
    chk("rst_err", {31'd0, frame_err}, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_code", {30'd0, err_code}, 32'd0);
    rst = 1'b0;
    rx_valid = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      o0 = ok_cnt;
      e0 = err_cnt;
      frame(v[i].addr, v[i].cnt, v[i].seed, v[i].step, v[i].dlt, 1'b0);
      repeat (4) @(negedge clk);
      chk($sformatf("v%0d_ok", i), ok_cnt - o0, {31'd0, v[i].ok});
      chk($sformatf("v%0d_err", i), err_cnt - e0, {31'd0, !v[i].ok});
      chk($sformatf("v%0d_code", i), {30'd0, err_code}, {30'd0, v[i].code});
      chk($sformatf("v%0d_busy", i), {31'd0, busy}, 32'd0);
      chk($sformatf("v%0d_pending", i), q.size(), 32'd0);
    end

    o0 = ok_cnt;
    e0 = err_cnt;
    send(8'h55);
    send(8'h00); send(8'h20); send(8'h00); send(8'h00);
    send(8'h01);
    send(8'hA1); send(8'hA2);
    repeat (95) @(negedge clk);
    chk("to_early_busy", {31'd0, busy}, 32'd1);
    chk("to_early_err", err_cnt - e0, 32'd0);
    repeat (10) @(negedge clk);
    chk("to_err", err_cnt - e0, 32'd1);
    chk("to_code", {30'd0, err_code}, 32'd3);
    chk("to_busy", {31'd0, busy}, 32'd0);
    frame(32'h0000_2000, 8'd1, 32'h1234_5678, 32'd0, 8'd0, 1'b0);
    repeat (4) @(negedge clk);
    chk("to_after_ok", ok_cnt - o0, 32'd1);
    chk("to_after_code", {30'd0, err_code}, 32'd0);
    chk("to_after_pending", q.size(), 32'd0);

    o0 = ok_cnt;
    e0 = err_cnt;
    w0 = wr_cnt;
    rnd_ready = 1;
    frame(32'h0000_8000, 8'd0, 32'd0, 32'd0, 8'd0, 1'b1);
    rnd_ready = 0;
    repeat (4) @(negedge clk);
    chk("c256_writes", wr_cnt - w0, 32'd256);
    chk("c256_ok", ok_cnt - o0, 32'd1);
    chk("c256_err", err_cnt - e0, 32'd0);
    chk("c256_pending", q.size(), 32'd0);

    o0 = ok_cnt;
    e0 = err_cnt;
    send(8'hAA);
    send(8'h00);
    repeat (3) @(negedge clk);
    chk("garbage_busy", {31'd0, busy}, 32'd0);
    send(8'h55);
    send(8'h00); send(8'h30); send(8'h00); send(8'h00);
    send(8'h02);
    send(8'h0D); send(8'h0C); send(8'h0B);
    q.push_back('{32'h0000_3000, 32'h0A0B_0C0D});
    send(8'h0A);
    send(8'h01); send(8'h02);
    chk("mid_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    q.delete();
    @(negedge clk);
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mid_ok", ok_cnt - o0, 32'd0);
    chk("rst_mid_err", err_cnt - e0, 32'd0);
    frame(32'h0000_3000, 8'd2, 32'hCAFE_0001, 32'h0000_0010, 8'd0, 1'b0);
    repeat (4) @(negedge clk);
    chk("clean_ok", ok_cnt - o0, 32'd1);
    chk("clean_err", err_cnt - e0, 32'd0);
    chk("clean_pending", q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
